muldiv_unit: RTL

//  Multi-cycle RV32M multiply/divide unit in the execute stage, parallel to the ALU.

---
 rtl/muldiv_unit_if.sv | 31 +++
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module   : muldiv_unit_if
// Purpose  : Request/response bundle between the execute stage and muldiv_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
    parameter int D_WIDTH = 32
) ();
    logic               start_i;
    logic               flush_i;
    logic [2:0]         funct3_i;
    logic [D_WIDTH-1:0] op1_i;
    logic [D_WIDTH-1:0] op2_i;
    logic               busy_o;
    logic               done_o;
    logic [D_WIDTH-1:0] result_o;

    modport master (
        output start_i, flush_i, funct3_i, op1_i, op2_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, flush_i, funct3_i, op1_i, op2_i,
        output busy_o, done_o, result_o
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Multi-cycle RV32M multiply (1 cycle) / restoring divide (D_WIDTH cycles).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int D_WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    muldiv_unit_if.slave      bus
);

    localparam int CNT_W = $clog2(D_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [D_WIDTH-1:0] MIN_INT  = {1'b1, {(D_WIDTH-1){1'b0}}};
    localparam logic [D_WIDTH-1:0] ALL_ONES = {D_WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(D_WIDTH - 1);

    logic [1:0]         state_q,  state_d;
    logic [1:0]         fn_q,     fn_d;
    logic [D_WIDTH-1:0] a_q,      a_d;
    logic [D_WIDTH-1:0] b_q,      b_d;
    logic [D_WIDTH-1:0] rem_q,    rem_d;
    logic               neg_q,    neg_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [D_WIDTH-1:0] result_q, result_d;

    logic                 accept;
    logic                 in_signed;
    logic [D_WIDTH-1:0]   op1_abs;
    logic [D_WIDTH-1:0]   op2_abs;
    logic                 mul_s1;
    logic                 mul_s2;
    logic [2*D_WIDTH-1:0] mul_a;
    logic [2*D_WIDTH-1:0] mul_b;
    logic [2*D_WIDTH-1:0] product;
    logic [D_WIDTH:0]     rem_shift;
    logic [D_WIDTH:0]     diff;
    logic                 qbit;
    logic [D_WIDTH-1:0]   rem_nxt;
    logic [D_WIDTH-1:0]   quo_nxt;
    logic [D_WIDTH-1:0]   div_raw;
    logic [D_WIDTH-1:0]   div_res;

    assign accept    = bus.start_i & ~bus.flush_i & (state_q == S_IDLE);
    // DIV and REM are the signed divide ops (funct3 = 1x0)
    assign in_signed = ~bus.funct3_i[0];
    assign op1_abs   = (in_signed & bus.op1_i[D_WIDTH-1]) ? -bus.op1_i : bus.op1_i;
    assign op2_abs   = (in_signed & bus.op2_i[D_WIDTH-1]) ? -bus.op2_i : bus.op2_i;

    // fn_q: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
    assign mul_s1  = (fn_q == 2'b01) | (fn_q == 2'b10);
    assign mul_s2  = (fn_q == 2'b01);
    assign mul_a   = {{D_WIDTH{mul_s1 & a_q[D_WIDTH-1]}}, a_q};
    assign mul_b   = {{D_WIDTH{mul_s2 & b_q[D_WIDTH-1]}}, b_q};
    assign product = mul_a * mul_b;

    // One restoring step: a_q shifts the dividend out and the quotient in
    assign rem_shift = {rem_q, a_q[D_WIDTH-1]};
    assign diff      = rem_shift - {1'b0, b_q};
    assign qbit      = ~diff[D_WIDTH];
    assign rem_nxt   = qbit ? diff[D_WIDTH-1:0] : rem_shift[D_WIDTH-1:0];
    assign quo_nxt   = {a_q[D_WIDTH-2:0], qbit};
    assign div_raw   = fn_q[1] ? rem_nxt : quo_nxt;
    assign div_res   = neg_q ? -div_raw : div_raw;

    always_comb begin
        state_d  = state_q;
        fn_d     = fn_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    fn_d = bus.funct3_i[1:0];
                    if (!bus.funct3_i[2]) begin
                        a_d     = bus.op1_i;
                        b_d     = bus.op2_i;
                        state_d = S_MUL;
                    end else if (bus.op2_i == '0) begin
                        result_d = bus.funct3_i[1] ? bus.op1_i : ALL_ONES;
                        state_d  = S_DONE;
                    end else if (in_signed && bus.op1_i == MIN_INT && bus.op2_i == ALL_ONES) begin
                        result_d = bus.funct3_i[1] ? '0 : MIN_INT;
                        state_d  = S_DONE;
                    end else begin
                        a_d     = op1_abs;
                        b_d     = op2_abs;
                        rem_d   = '0;
                        cnt_d   = '0;
                        neg_d   = in_signed & (bus.funct3_i[1] ? bus.op1_i[D_WIDTH-1]
                                              : (bus.op1_i[D_WIDTH-1] ^ bus.op2_i[D_WIDTH-1]));
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                result_d = (fn_q == 2'b00) ? product[D_WIDTH-1:0] : product[2*D_WIDTH-1:D_WIDTH];
                state_d  = S_DONE;
            end
            S_DIV: begin
                a_d   = quo_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    result_d = div_res;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An aborted operation must leave the previous result visible
        if (bus.flush_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            fn_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            fn_q     <= fn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.done_o   = (state_q == S_DONE);
    assign bus.result_o = result_q;

endmodule

`default_nettype wire
